// File: rtl/qmult_arb_pkg.sv
// Shared types and constants for the Q-format multiplier arbiter.
// The FSM encoding and the ack-counter width rule live here.
package qmult_arb_pkg;

   localparam int DEF_N        = 32;
   localparam int DEF_Q        = 15;
   localparam int DEF_NREQ     = 4;
   localparam int DEF_ACK_WAIT = 4;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_RESPOND   = 2'd3
   } state_t;

   function automatic int ack_cnt_width(input int ack_wait);
      return $clog2(ack_wait + 1);
   endfunction

   localparam int ACK_CW = ack_cnt_width(DEF_ACK_WAIT);

endpackage

// File: rtl/qmult_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping modulo NREQ, returned both one-hot and as an index.
module rr_pick
   import qmult_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [PW-1:0]   o_idx,
   output logic            o_any
);

   logic [NREQ-1:0] w_grant;
   logic [PW-1:0]   w_idx;
   logic            w_found;

   // Scan from the pointer, stopping at the first active request.
   always_comb begin
      w_grant = '0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         int pos;
         pos = (int'(i_ptr) + i) % NREQ;
         if (!w_found && i_req[pos]) begin
            w_found      = 1'b1;
            w_grant[pos] = 1'b1;
            w_idx        = PW'(pos);
         end else begin
            w_found = w_found;
         end
      end
   end

   assign o_grant = w_grant;
   assign o_idx   = w_idx;
   assign o_any   = w_found;

endmodule

// File: rtl/qmult_arbiter.sv
// Round-robin front end sharing one sequential signed-magnitude multiplier
// among NREQ requesters; all outputs registered.
module qmult_arbiter
   import qmult_arb_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int Q        = DEF_Q,
   parameter int NREQ     = DEF_NREQ,
   parameter int ACK_WAIT = DEF_ACK_WAIT
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [NREQ-1:0] i_req,
   input  logic [NREQ*N-1:0] i_a,
   input  logic [NREQ*N-1:0] i_b,
   output logic [NREQ-1:0] o_grant,
   output logic [NREQ-1:0] o_valid,
   output logic [N-1:0]    o_result,
   output logic            o_overflow,
   output logic            o_err,
   output logic            o_mul_start,
   output logic [N-1:0]    o_mul_a,
   output logic [N-1:0]    o_mul_b,
   input  logic [N-1:0]    i_mul_result,
   input  logic            i_mul_complete,
   input  logic            i_mul_overflow
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = ack_cnt_width(ACK_WAIT);

   // Q only names the fixed-point format; a value outside the word is a misconfiguration.
   if (Q >= N) begin : g_bad_q_cfg
   end

   state_t          r_state;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   r_win;
   logic [CW-1:0]   r_ack;
   logic [NREQ-1:0] r_grant;
   logic [NREQ-1:0] r_valid;
   logic [N-1:0]    r_result;
   logic            r_overflow;
   logic            r_err;
   logic            r_start;
   logic [N-1:0]    r_mul_a;
   logic [N-1:0]    r_mul_b;

   logic [NREQ-1:0] w_grant;
   logic [PW-1:0]   w_idx;
   logic            w_any;
   logic [N-1:0]    w_a;
   logic [N-1:0]    w_b;
   logic [PW-1:0]   w_ptr_next;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .i_req   (i_req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // One-hot AND-OR operand mux selected by the picker.
   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_a = w_a | (i_a[k*N +: N] & {N{w_grant[k]}});
         w_b = w_b | (i_b[k*N +: N] & {N{w_grant[k]}});
      end
   end

   assign w_ptr_next = (r_win == PW'(NREQ - 1)) ? '0 : r_win + PW'(1);

   // Arbitration / handshake FSM with all outputs registered.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_win      <= '0;
         r_ack      <= '0;
         r_grant    <= '0;
         r_valid    <= '0;
         r_result   <= '0;
         r_overflow <= 1'b0;
         r_err      <= 1'b0;
         r_start    <= 1'b0;
         r_mul_a    <= '0;
         r_mul_b    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // A busy multiplier (e.g. left over from a reset) blocks new grants.
               if (i_mul_complete && w_any) begin
                  r_grant <= w_grant;
                  r_win   <= w_idx;
                  r_mul_a <= w_a;
                  r_mul_b <= w_b;
                  r_start <= 1'b1;
                  r_ack   <= '0;
                  r_state <= ST_ISSUE;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               if (!i_mul_complete) begin
                  r_start <= 1'b0;
                  r_state <= ST_WAIT_DONE;
               end else if (r_ack == CW'(ACK_WAIT - 1)) begin
                  r_start    <= 1'b0;
                  r_result   <= '0;
                  r_overflow <= 1'b0;
                  r_err      <= 1'b1;
                  r_valid    <= r_grant;
                  r_state    <= ST_RESPOND;
               end else begin
                  r_ack <= r_ack + CW'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (i_mul_complete) begin
                  r_result   <= i_mul_result;
                  r_overflow <= i_mul_overflow;
                  r_valid    <= r_grant;
                  r_state    <= ST_RESPOND;
               end else begin
                  r_state <= ST_WAIT_DONE;
               end
            end
            ST_RESPOND: begin
               r_valid <= '0;
               r_err   <= 1'b0;
               r_grant <= '0;
               r_ptr   <= w_ptr_next;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_grant     = r_grant;
   assign o_valid     = r_valid;
   assign o_result    = r_result;
   assign o_overflow  = r_overflow;
   assign o_err       = r_err;
   assign o_mul_start = r_start;
   assign o_mul_a     = r_mul_a;
   assign o_mul_b     = r_mul_b;

endmodule

// File: doc/qmult_arbiter.md
Name: qmult_arbiter

Overview:
- Shares one sequential signed-magnitude Q-format multiplier (qmults: start/complete/overflow handshake) among NREQ requesters.
- Round-robin arbitration; latches the winner's operands, sequences the multiplier's start/complete handshake, and returns the result, overflow and a one-cycle valid pulse to the winner.
- Sits between the control-loop blocks (PID/odometry) and the single shared multiplier instance.

Parameters:
- N, 32, word width of operands/result (sign bit = MSB, magnitude below).
- Q, 15, fractional bits; passed through for documentation and bench only, no arithmetic here.
- NREQ, 4, number of requesters (2..8).
- ACK_WAIT, 4, max cycles in ISSUE waiting for i_mul_complete to fall before error.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  NREQ  per-requester request level; held until that requester's o_valid bit.
- i_a  in  NREQ*N  flattened multiplicands; requester k at [k*N +: N].
- i_b  in  NREQ*N  flattened multipliers, same packing.
- o_grant  out  NREQ  one-hot owner of the multiplier; zero when idle.
- o_valid  out  NREQ  one-hot, one-cycle pulse: o_result/o_overflow valid for that requester.
- o_result  out  N  registered product, shared by all requesters.
- o_overflow  out  1  registered overflow, qualified by o_valid.
- o_err  out  1  one-cycle pulse, with o_valid, when the multiplier failed to acknowledge start.
- o_mul_start  out  1  to multiplier i_start.
- o_mul_a  out  N  to multiplier i_multiplicand.
- o_mul_b  out  N  to multiplier i_multiplier.
- i_mul_result  in  N  from multiplier o_result_out.
- i_mul_complete  in  1  from multiplier o_complete (high = idle/done).
- i_mul_overflow  in  1  from multiplier o_overflow.

Behaviour:
- Reset (async, active-low): state IDLE; o_grant, o_valid, o_result, o_overflow, o_err, o_mul_start, o_mul_a, o_mul_b = 0; round-robin pointer = 0 (requester 0 highest priority).
- All outputs are registered.
- IDLE:
  - Wait until i_mul_complete=1 and |i_req.
  - Pick the first requesting index at or after the pointer, wrapping modulo NREQ.
  - At the edge: set o_grant, latch i_a/i_b slice into o_mul_a/o_mul_b, o_mul_start=1, clear ack counter, go ISSUE.
  - With i_mul_complete=0 (e.g. multiplier still busy after an arbiter reset mid-operation), no grant is issued.
- ISSUE:
  - Hold o_mul_start=1 and operands.
  - i_mul_complete=0 seen: o_mul_start=0, go WAIT_DONE.
  - Otherwise increment the ack counter. When it reaches ACK_WAIT: o_mul_start=0, o_result=0, o_overflow=0, o_err=1, winner's o_valid=1, go RESPOND.
- WAIT_DONE:
  - Operands held stable.
  - i_mul_complete=1: o_result<=i_mul_result, o_overflow<=i_mul_overflow, winner's o_valid=1, go RESPOND.
- RESPOND (one cycle):
  - o_valid, o_err -> 0; o_grant -> 0.
  - Pointer <= winner+1 (wraps NREQ-1 -> 0). Go IDLE.
- Latency: request in IDLE with multiplier idle -> o_valid = N+4 cycles after the sampling edge (36 for N=32). Back-to-back service by alternating requesters is N+6 cycles per operation.
- Fairness: a requester waits at most NREQ-1 services.
- Request dropped after grant: the operation still completes and o_valid still pulses; the result is discarded by the requester.
- Request changes on non-granted lines during an operation: ignored until IDLE.
- Simultaneous requests at RESPOND: arbitrated in the next IDLE cycle with the updated pointer.
- o_result and o_overflow hold their last value between valids.

Decomposition:
- Package qmult_arb_pkg:
  - state encoding (IDLE, ISSUE, WAIT_DONE, RESPOND);
  - ack counter width constant ($clog2(ACK_WAIT+1));
  - default N/Q/NREQ constants.
- Sub-module rr_pick: combinational round-robin one-hot picker (inputs req, pointer; outputs one-hot grant, index). FSM, operand mux and registers stay in qmult_arbiter.

Test Plan:
- Single op, Q15/N32: req0, a=0x0000C000 (1.5), b=0x00010000 (2.0) -> o_valid[0] at +36 cycles, o_result=0x00018000, o_overflow=0, o_err=0.
- Sign: req2, a=0x8000C000 (-1.5), b=0x00010000 -> o_result=0x80018000. Also (-1.5)x(-2.0) -> 0x00018000.
- Overflow: a=0x40000000, b=0x00010000 -> o_valid with o_overflow=1.
- Round-robin:
  - all four i_req held high from reset -> services in order 0,1,2,3,0.
  - only req1 and req3 high -> 1,3,1,3.
  - o_grant is always one-hot or zero.
- Reset mid-operation: assert i_rst_n=0 in WAIT_DONE -> all outputs 0 immediately. After release with the multiplier still busy, no grant until i_mul_complete=1. The next operation's result is correct.
- Ack timeout: tie i_mul_complete=1 -> after ACK_WAIT=4 ISSUE cycles, o_err and o_valid pulse together with o_result=0, then the pointer advances.
